// File: rtl/edge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : edge_pkg
// Description : Shared types and helpers for the multi-channel edge detector.
// Revision    : 1.0 - initial release
// ============================================================================
package edge_pkg;

  // Per-channel edge qualification mode; bit 0 enables rising, bit 1 falling.
  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // Width of a counter that must hold values 0..cycles-1 without wrapping.
  // Never returns less than 1 so a single-cycle debounce still has a counter.
  function automatic int calc_cnt_w(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_channel.sv
`default_nettype none
// ============================================================================
// Module      : edge_channel
// Description : One input channel: synchroniser, debounce counter, stable
//               level, registered rise/fall/qualified pulses, sticky flag.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_channel
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       sig_i,
  input  edge_mode_t mode_i,
  input  logic       clr_i,
  output logic       level_o,
  output logic       rise_o,
  output logic       fall_o,
  output logic       pulse_o,
  output logic       pulse_next_o,
  output logic       evt_o
);

  localparam int              CNT_W    = calc_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject illegal synchroniser depths at elaboration time.
  generate
    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
      $error("edge_channel: SYNC_STAGES must be in 2..4");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   stable_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   pulse_q;
  logic                   evt_q;

  logic mismatch;
  logic flip;
  logic rise_d;
  logic fall_d;
  logic pulse_d;
  logic rise_en;
  logic fall_en;

  // Metastability chain; only the last stage is used by downstream logic.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_chain <= '0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], sig_i};
    end
  end

  assign sync_q = sync_chain[SYNC_STAGES-1];

  // Decide whether this cycle accepts a level change and which edge it is.
  always_comb begin
    mismatch = 1'b0;
    flip     = 1'b0;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    rise_en  = 1'b0;
    fall_en  = 1'b0;
    pulse_d  = 1'b0;
    mismatch = (sync_q != stable_q);
    flip     = mismatch && (cnt_q == TERM_CNT);
    rise_d   = flip && sync_q;
    fall_d   = flip && !sync_q;
    // Mode is sampled at the flip edge, so a mode change never acts retroactively.
    rise_en  = (mode_i == EDGE_RISE) || (mode_i == EDGE_BOTH);
    fall_en  = (mode_i == EDGE_FALL) || (mode_i == EDGE_BOTH);
    pulse_d  = (rise_d && rise_en) || (fall_d && fall_en);
  end

  // Debounce counter: counts consecutive mismatch cycles, restarts on agreement.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (!mismatch) begin
      cnt_q <= '0;
    end else if (cnt_q == TERM_CNT) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Accepted (debounced) level; resets low so a held-high input yields a rise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable_q <= 1'b0;
    end else if (flip) begin
      stable_q <= sync_q;
    end
  end

  // One-cycle edge pulses, aligned with the level change.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      pulse_q <= pulse_d;
    end
  end

  // Sticky event flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      evt_q <= 1'b0;
    end else begin
      evt_q <= pulse_q || (evt_q && !clr_i);
    end
  end

  assign level_o      = stable_q;
  assign rise_o       = rise_q;
  assign fall_o       = fall_q;
  assign pulse_o      = pulse_q;
  assign pulse_next_o = pulse_d;
  assign evt_o        = evt_q;

endmodule
`default_nettype wire

// File: rtl/edge_detector_multi.sv
`default_nettype none
// ============================================================================
// Module      : edge_detector_multi
// Description : N_CH independent debounced edge detectors with per-channel
//               run-time edge mode, sticky event flags and a combined pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_detector_multi
  import edge_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [N_CH-1:0]   sig_i,
  input  logic [2*N_CH-1:0] mode_i,
  input  logic [N_CH-1:0]   clr_i,
  output logic [N_CH-1:0]   level_o,
  output logic [N_CH-1:0]   rise_o,
  output logic [N_CH-1:0]   fall_o,
  output logic [N_CH-1:0]   pulse_o,
  output logic [N_CH-1:0]   evt_o,
  output logic              any_o
);

  logic [N_CH-1:0] pulse_next;
  logic            any_q;

  generate
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
      edge_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_channel (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .sig_i        (sig_i[c]),
        .mode_i       (edge_mode_t'(mode_i[2*c +: 2])),
        .clr_i        (clr_i[c]),
        .level_o      (level_o[c]),
        .rise_o       (rise_o[c]),
        .fall_o       (fall_o[c]),
        .pulse_o      (pulse_o[c]),
        .pulse_next_o (pulse_next[c]),
        .evt_o        (evt_o[c])
      );
    end
  endgenerate

  // Combined pulse, registered from the same next-state terms as pulse_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      any_q <= 1'b0;
    end else begin
      any_q <= |pulse_next;
    end
  end

  assign any_o = any_q;

endmodule
`default_nettype wire

// File: tb/tb_edge_detector_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_edge_detector_multi
// Description : Directed self-checking bench for edge_detector_multi
//               (N_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_detector_multi;

  logic       clk;
  logic       rst_n;
  logic [3:0] sig;
  logic [7:0] mode;
  logic [3:0] clr;
  logic [3:0] level;
  logic [3:0] rise;
  logic [3:0] fall;
  logic [3:0] pulse;
  logic [3:0] evt;
  logic       any;

  int total;
  int bad;

  edge_detector_multi #(
    .N_CH            (4),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .sig_i   (sig),
    .mode_i  (mode),
    .clr_i   (clr),
    .level_o (level),
    .rise_o  (rise),
    .fall_o  (fall),
    .pulse_o (pulse),
    .evt_o   (evt),
    .any_o   (any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check every output bus at once.
  task automatic chk_all(input string tag, input logic [3:0] e_level, input logic [3:0] e_rise,
                         input logic [3:0] e_fall, input logic [3:0] e_pulse,
                         input logic [3:0] e_evt, input logic e_any);
    chk({tag, ".level"}, {4'h0, level}, {4'h0, e_level});
    chk({tag, ".rise"},  {4'h0, rise},  {4'h0, e_rise});
    chk({tag, ".fall"},  {4'h0, fall},  {4'h0, e_fall});
    chk({tag, ".pulse"}, {4'h0, pulse}, {4'h0, e_pulse});
    chk({tag, ".evt"},   {4'h0, evt},   {4'h0, e_evt});
    chk({tag, ".any"},   {7'h0, any},   {7'h0, e_any});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    sig   = 4'h0;
    mode  = 8'h00;
    clr   = 4'h0;

    // Reset state
    tick(2);
    chk_all("reset", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    rst_n = 1'b1;
    tick(2);
    chk_all("idle", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

    // Clean press on ch0, mode rising
    mode = 8'b00_00_00_01;
    sig  = 4'b0001;
    tick(5);
    chk_all("press.e5", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    tick(1);
    chk_all("press.e6", 4'h1, 4'h1, 4'h0, 4'h1, 4'h0, 1'b1);
    tick(1);
    chk_all("press.e7", 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 1'b0);
    tick(3);
    chk("press.hold_evt", {4'h0, evt}, 8'h01);
    clr = 4'b0001;
    tick(1);
    clr = 4'b0000;
    chk("press.cleared", {4'h0, evt}, 8'h00);
    sig = 4'b0000;
    tick(6);
    chk_all("release", 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0);

    // Glitch of 3 cycles on ch1 must be rejected
    mode = 8'b00_00_01_01;
    sig  = 4'b0010;
    tick(3);
    sig  = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("glitch.rise", {4'h0, rise}, 8'h00);
      chk("glitch.level", {4'h0, level}, 8'h00);
    end
    chk_all("glitch.end", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

    // Modes 00/01/10/11 on ch0..3, clear race on ch3
    mode = 8'b11_10_01_00;
    sig  = 4'b1111;
    tick(6);
    chk_all("modes.rise", 4'hF, 4'hF, 4'h0, 4'hA, 4'h0, 1'b1);
    tick(1);
    chk_all("modes.rise_evt", 4'hF, 4'h0, 4'h0, 4'h0, 4'hA, 1'b0);
    clr = 4'b1000;
    tick(1);
    clr = 4'b0000;
    chk("modes.clr3", {4'h0, evt}, 8'h02);
    tick(2);
    sig = 4'b0000;
    tick(6);
    chk_all("modes.fall", 4'h0, 4'h0, 4'hF, 4'hC, 4'h2, 1'b1);
    clr = 4'b1000;
    tick(1);
    chk("race.set_wins", {4'h0, evt}, 8'h0E);
    chk("race.pulse_gone", {4'h0, pulse}, 8'h00);
    tick(1);
    clr = 4'b0000;
    chk("race.cleared", {4'h0, evt}, 8'h06);

    // Reset mid-count on ch2
    sig = 4'b0100;
    tick(3);
    rst_n = 1'b0;
    #1;
    chk_all("midrst.assert", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    tick(2);
    chk_all("midrst.held", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    rst_n = 1'b1;
    tick(5);
    chk_all("midrst.e5", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    tick(1);
    chk_all("midrst.e6", 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 1'b0);

    // Mode change on ch1 while its rise is debouncing
    mode = 8'b11_10_01_00;
    sig  = 4'b0110;
    tick(3);
    mode = 8'b11_10_10_00;
    tick(3);
    chk_all("modechg.rise", 4'h6, 4'h2, 4'h0, 4'h0, 4'h0, 1'b0);
    tick(1);
    chk("modechg.no_evt", {4'h0, evt}, 8'h00);
    sig = 4'b0100;
    tick(5);
    chk("modechg.fall_e5", {4'h0, pulse}, 8'h00);
    tick(1);
    chk_all("modechg.fall", 4'h4, 4'h0, 4'h2, 4'h2, 4'h0, 1'b1);
    tick(1);
    chk_all("modechg.evt", 4'h4, 4'h0, 4'h0, 4'h0, 4'h2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/edge_detector_multi.md
Name: edge_detector_multi

Overview:
- Parametrised, multi-channel successor to the single-signal edge detector.
- Per channel: synchronises an asynchronous input (button, coin sensor), debounces it, and emits a one-cycle qualified pulse on rising, falling or both edges, selected per channel at run time.
- Each channel also has a sticky event flag with per-channel clear, so slower FSMs (vending-machine controller) can poll events.
- Sits between board I/O pins and the control FSM.

Parameters:
- N_CH, 4, number of independent channels.
- SYNC_STAGES, 2, synchroniser flip-flops per channel; legal range 2..4.
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a level change (10 ms at 25 MHz); minimum 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), localparam; debounce counter width.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- sig_i  in  N_CH  raw asynchronous inputs.
- mode_i  in  2*N_CH  per-channel edge mode, channel c at bits [2c+1:2c]: 00 none, 01 rising, 10 falling, 11 both.
- clr_i  in  N_CH  per-channel sticky-flag clear, synchronous.
- level_o  out  N_CH  debounced level.
- rise_o  out  N_CH  one-cycle pulse on accepted 0->1; independent of mode.
- fall_o  out  N_CH  one-cycle pulse on accepted 1->0; independent of mode.
- pulse_o  out  N_CH  one-cycle pulse on an accepted edge qualified by mode_i.
- evt_o  out  N_CH  sticky flag, set by pulse_o.
- any_o  out  1  OR of pulse_o (registered along with pulse_o, same cycle).

Behaviour:
- Reset (rst_ni low, asynchronous): sync chain, counters, stable levels, all outputs = 0. Reset mid-operation aborts any count in progress; no pulse is produced.
- Sync: SYNC_STAGES-deep flop chain per channel. Only the last stage (sync_q) feeds the logic.
- Debounce, per channel, each cycle:
  - sync_q == stable_q: counter <= 0.
  - sync_q != stable_q and counter == DEBOUNCE_CYCLES-1: stable_q <= sync_q, counter <= 0.
  - Otherwise: counter <= counter + 1.
  - Any reversion before terminal count restarts the count. Glitches shorter than DEBOUNCE_CYCLES produce no event.
- Latency: a new input value first sampled at edge 1 is reflected on level_o at edge SYNC_STAGES + DEBOUNCE_CYCLES.
- Edge outputs are registered and asserted in the same cycle level_o changes, for exactly one cycle:
  - rise_o: 0->1 transition.
  - fall_o: 1->0 transition.
  - pulse_o: (rise & mode[0]) | (fall & mode[1]), using mode_i sampled at the flip edge. A mode change takes effect on the next accepted edge; no retroactive pulses.
- evt_o: set on pulse_o; cleared on clr_i. Same-cycle set and clear: set wins (event never lost). Clear with no event: stays 0.
- Channels are fully independent. Simultaneous edges on several channels each produce their own pulses.
- An input held high across reset release yields rise_o after the normal latency (reset level is 0).
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap.

Decomposition:
- Package edge_pkg:
  - typedef enum logic [1:0] edge_mode_t {EDGE_NONE, EDGE_RISE, EDGE_FALL, EDGE_BOTH}.
  - Localparam function for CNT_W.
- Sub-module edge_channel: one channel's sync chain, debounce counter, stable level, rise/fall/pulse regs and sticky flag.
- Top: generate-for over N_CH, plus the any_o OR.

Test Plan (N_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, 10 ns clock):
- Clean press: ch0 mode=01, sig_i[0] 0->1 held 100 ns -> level_o[0] high at edge 6 after change; rise_o[0], pulse_o[0], any_o high one cycle; evt_o[0]=1 until clr_i[0].
- Glitch reject: sig_i[1] high for 3 cycles, then low -> level_o, rise_o, pulse_o, evt_o stay 0 for ch1.
- Modes: ch0..3 modes 00/01/10/11, all inputs pulse high 10 cycles -> rise_o/fall_o on all channels; pulse_o only ch1 (rise), ch2 (fall), ch3 (both, 2 pulses); ch0 none.
- Clear race: assert clr_i[3] in the exact cycle pulse_o[3] fires -> evt_o[3]=1 next cycle; clr_i[3] one cycle later -> evt_o[3]=0.
- Reset mid-count: sig_i[2] high, rst_ni low after 3 cycles for 2 cycles, input still high -> all outputs 0 during reset; rise_o[2] fires 6 cycles after release.
- Mode change: ch1 mode 01->10 while input debouncing high -> no pulse_o on that rise; falling edge later -> pulse_o[1].
